decoder_stream_encoder: RTL and testbench

- Sequential 16-to-4 encoder. It is the inverse of the team's 4-to-16 decoder (`decoder`).
- Accepts a 16-bit request vector `d` over a valid/ready handshake and emits the 4-bit code of every set bit, one code per handshake beat, in priority order.
- Uses the same bit mapping as `decoder`:
  - code n = {x,y,z,w} corresponds to d[15-n];
  - d=16'b1000000000000000 -> code 0000;
  - d=16'b0001000000000000 -> code 0011.
- Sits upstream of `decoder` in the lab datapath, so that decoder(encoder(d)) reproduces each one-hot component of d.

---
 rtl/decoder_stream_encoder.sv | 120 ++++++++++++
 tb/tb_decoder_stream_encoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_stream_encoder.sv
// Sequential 16-to-4 encoder: streams the 4-bit code of every set bit of an
// accepted request vector, highest priority (d[15], code 0) first.
module decoder_stream_encoder #(
    parameter bit REPORT_EMPTY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] d,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic        w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        last,
    output logic        none,
    output logic [4:0]  remaining
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic        none_q, none_d;
    logic [3:0]  code_s;
    logic [4:0]  count_s;
    logic        emit_s;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

    // Priority encode pend: the smallest code n with pend[15-n] set wins.
    always_comb begin
        code_s = 4'd0;
        for (int n = 15; n >= 0; n--) begin
            if (pend_q[15-n]) begin
                code_s = 4'(n);
            end else begin
                code_s = code_s;
            end
        end
    end

    assign count_s = popcount16(pend_q);

    // Next-state logic; enable low freezes everything including the none pulse.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;
        if (enable) begin
            none_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pend_d = d;
                        if (d != 16'd0) begin
                            state_d = EMIT;
                        end else begin
                            state_d = IDLE;
                            none_d  = REPORT_EMPTY;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pend_d = pend_q & ~(16'h8000 >> code_s);
                        if (count_s == 5'd1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = EMIT;
                        end
                    end else begin
                        state_d = EMIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pend_d  = 16'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 16'd0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
        end
    end

    // rst masks the outputs so the reset cycle always reads as fully idle.
    assign emit_s       = ~rst & (state_q == EMIT);
    assign in_ready     = ~rst & enable & (state_q == IDLE);
    assign out_valid    = emit_s & enable;
    assign {x, y, z, w} = emit_s ? code_s : 4'd0;
    assign last         = emit_s & (count_s == 5'd1);
    assign remaining    = emit_s ? count_s : 5'd0;
    assign none         = ~rst & none_q;

endmodule

// File: tb/tb_decoder_stream_encoder.sv
// Directed self-checking bench for decoder_stream_encoder.
module tb_decoder_stream_encoder;

    logic        clk = 1'b0;
    logic        rst, enable, in_valid, out_ready;
    logic [15:0] d;
    logic        in_ready, x, y, z, w, out_valid, last, none;
    logic [4:0]  remaining;
    logic        in_ready_b, x_b, y_b, z_b, w_b, out_valid_b, last_b, none_b;
    logic [4:0]  remaining_b;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    decoder_stream_encoder #(.REPORT_EMPTY(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .d(d), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .y(y), .z(z), .w(w), .out_valid(out_valid),
        .out_ready(out_ready), .last(last), .none(none), .remaining(remaining)
    );

    decoder_stream_encoder #(.REPORT_EMPTY(1'b0)) dut_quiet (
        .clk(clk), .rst(rst), .enable(enable), .d(d), .in_valid(in_valid),
        .in_ready(in_ready_b), .x(x_b), .y(y_b), .z(z_b), .w(w_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .last(last_b),
        .none(none_b), .remaining(remaining_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, land 1ns after the edge for driving inputs.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] code,
                            input logic lst, input logic [4:0] rem);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".code"},  {28'd0, x, y, z, w}, {28'd0, code});
        chk({tag, ".last"},  {31'd0, last}, {31'd0, lst});
        chk({tag, ".rem"},   {27'd0, remaining}, {27'd0, rem});
        chk({tag, ".none"},  {31'd0, none}, 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".code"},  {28'd0, x, y, z, w}, 32'd0);
        chk({tag, ".rem"},   {27'd0, remaining}, 32'd0);
    endtask

    // Present a vector for one accepting edge and settle on the first beat cycle.
    task automatic send(input logic [15:0] v);
        d        = v;
        in_valid = 1'b1;
        settle();
        chk("send.in_ready", {31'd0, in_ready}, 32'd1);
        adv();
        in_valid = 1'b0;
        settle();
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        d         = 16'd0;
        #1;
        settle();
        chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        adv();
        adv();
        rst = 1'b0;
        settle();
        chk_idle("post_rst");
        chk("post_rst.last", {31'd0, last}, 32'd0);
        chk("post_rst.none", {31'd0, none}, 32'd0);

        // Single highest-priority bit.
        send(16'h8000);
        chk_beat("v8000", 4'b0000, 1'b1, 5'd1);
        chk("v8000.in_ready", {31'd0, in_ready}, 32'd0);
        adv(); settle();
        chk_idle("v8000.done");

        // Single bit giving code 0011.
        send(16'h1000);
        chk_beat("v1000", 4'b0011, 1'b1, 5'd1);
        adv(); settle();
        chk_idle("v1000.done");

        // Three bits, full throughput.
        send(16'h9001);
        chk_beat("v9001.b0", 4'b0000, 1'b0, 5'd3);
        adv(); settle();
        chk_beat("v9001.b1", 4'b0011, 1'b0, 5'd2);
        adv(); settle();
        chk_beat("v9001.b2", 4'b1111, 1'b1, 5'd1);
        adv(); settle();
        chk_idle("v9001.done");

        // Backpressure on beat 2, then enable low on beat 3.
        send(16'h9001);
        chk_beat("bp.b0", 4'b0000, 1'b0, 5'd3);
        adv();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d         = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_beat("bp.hold", 4'b0011, 1'b0, 5'd2);
            adv();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        settle();
        chk_beat("bp.b1", 4'b0011, 1'b0, 5'd2);
        adv(); settle();
        chk_beat("bp.b2", 4'b1111, 1'b1, 5'd1);
        enable = 1'b0;
        settle();
        for (int i = 0; i < 2; i++) begin
            chk("en.valid", {31'd0, out_valid}, 32'd0);
            chk("en.in_ready", {31'd0, in_ready}, 32'd0);
            chk("en.code", {28'd0, x, y, z, w}, 32'hF);
            chk("en.rem", {27'd0, remaining}, 32'd1);
            adv(); settle();
        end
        enable = 1'b1;
        settle();
        chk_beat("en.resume", 4'b1111, 1'b1, 5'd1);
        adv(); settle();
        chk_idle("en.done");

        // All-zero vector: pulse only where REPORT_EMPTY is set.
        send(16'h0000);
        chk("zero.none", {31'd0, none}, 32'd1);
        chk("zero.none_quiet", {31'd0, none_b}, 32'd0);
        chk("zero.valid", {31'd0, out_valid}, 32'd0);
        chk("zero.in_ready", {31'd0, in_ready}, 32'd1);
        adv(); settle();
        chk("zero.none_end", {31'd0, none}, 32'd0);
        chk_idle("zero.done");

        // Full vector interrupted by reset after the fifth beat.
        send(16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            chk_beat("ffff", 4'(i), 1'b0, 5'(16 - i));
            if (i < 4) begin
                adv(); settle();
            end
        end
        rst = 1'b1;
        settle();
        chk("rst2.valid", {31'd0, out_valid}, 32'd0);
        chk("rst2.code", {28'd0, x, y, z, w}, 32'd0);
        chk("rst2.rem", {27'd0, remaining}, 32'd0);
        chk("rst2.in_ready", {31'd0, in_ready}, 32'd0);
        adv();
        rst = 1'b0;
        settle();
        chk_idle("rst2.after");
        adv(); settle();
        chk_idle("rst2.quiet");

        // Lowest-priority single bit.
        send(16'h0001);
        chk_beat("v0001", 4'b1111, 1'b1, 5'd1);
        adv(); settle();
        chk_idle("v0001.done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
